// File: rtl/shift_add_mult_pkg.sv
// Shared constants for the shift-add multiplier: FSM state encodings and
// the width-derived size of the iteration counter.
package shift_add_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Bits needed to count 0..width inclusive, i.e. ceil(log2(width+1)).
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Sequential shift-add multiplier: WIDTH cycles of add/shift on operand
// magnitudes, then one cycle to apply the sign and publish the product.
module shift_add_mult
  import shift_add_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = cnt_bits(WIDTH);

  state_t               state;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 neg;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 a_neg;
  logic                 b_neg;

  // The magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is exactly
  // right when the result is read back as unsigned.
  assign a_neg = signed_mode & a[WIDTH-1];
  assign b_neg = signed_mode & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + WIDTH'(1)) : a;
  assign b_mag = b_neg ? (~b + WIDTH'(1)) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= a_neg ^ b_neg;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          product <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed-vector bench for shift_add_mult at WIDTH=4 with hand-computed
// products, latency, back-to-back and mid-operation reset checks.
module tb_shift_add_mult;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total;
  int bad;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .signed_mode(signed_mode),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    total++;
    if (obs !== exp_val) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_val, exp_val);
    end
  endtask

  // One complete multiply; inputs are scrambled after the accept edge so
  // any late sampling shows up as a wrong product.
  task automatic apply_stimulus(input string tag, input logic sm, input logic [W-1:0] av,
                                input logic [W-1:0] bv, input logic [2*W-1:0] exp_p);
    int  k;
    int  busy_cnt;
    bit  got;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; signed_mode = ~sm; a = ~av; b = bv + 4'd3;
    k = 0; busy_cnt = 0; got = 1'b0;
    while (k < 20 && !got) begin
      if (busy) busy_cnt++;
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check_output({tag, "_done_seen"}, 32'(got), 32'd1);
    check_output({tag, "_latency"}, 32'(k), 32'(W + 1));
    check_output({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    check_output({tag, "_product"}, 32'(product), 32'(exp_p));
    @(negedge clk);
    check_output({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check_output({tag, "_product_held"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int k;
    int done_cnt;
    bit got;

    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    #12;
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    apply_stimulus("u5x3",   1'b0, 4'd5,  4'd3,  8'd15);
    apply_stimulus("u15x15", 1'b0, 4'd15, 4'd15, 8'd225);
    apply_stimulus("s-3x5",  1'b1, 4'hD,  4'd5,  8'hF1);
    apply_stimulus("s-8x-8", 1'b1, 4'h8,  4'h8,  8'd64);
    apply_stimulus("s-8x7",  1'b1, 4'h8,  4'd7,  8'hC8);
    apply_stimulus("s7x-1",  1'b1, 4'd7,  4'hF,  8'hF9);
    apply_stimulus("u0x9",   1'b0, 4'd0,  4'd9,  8'd0);
    apply_stimulus("u8x8",   1'b0, 4'd8,  4'd8,  8'd64);

    // Start ignored while busy, then a start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 4'd5; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'd7; b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    k = 0; got = 1'b0; done_cnt = 0;
    while (k < 20 && !got) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check_output("b2b_first_done", 32'(got), 32'd1);
    check_output("b2b_first_product", 32'(product), 32'd15);
    start = 1'b1; a = 4'd2; b = 4'd6;
    @(negedge clk);
    start = 1'b0; a = 4'd7; b = 4'd7;
    k = 1; got = 1'b0;
    while (k < 20 && !got) begin
      if (done) begin
        got = 1'b1;
        done_cnt++;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check_output("b2b_second_done", 32'(got), 32'd1);
    check_output("b2b_spacing", 32'(k), 32'(W + 2));
    check_output("b2b_second_product", 32'(product), 32'd12);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_output("b2b_no_extra_done", 32'(done_cnt), 32'd1);

    // Reset dropped at CALC cycle 2 aborts the operation.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 4'd5; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_product", 32'(product), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_output("abort_no_done", 32'(done_cnt), 32'd0);
    check_output("abort_product_after", 32'(product), 32'd0);
    apply_stimulus("post_reset_u6x7", 1'b0, 4'd6, 4'd7, 8'd42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin a multiply, sampled only in IDLE.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 treats a and b as two's complement, 0 as unsigned; sampled with start.
REQ-006 The block SHALL have port a, input, WIDTH bits: the multiplicand, sampled with start.
REQ-007 The block SHALL have port b, input, WIDTH bits: the multiplier, sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in CALC or SIGN.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking that product is valid.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: the result, registered and held until the next accepted start.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and SIGN.
REQ-012 In IDLE, on a sampled start=1, the block SHALL latch |a| and |b| (magnitudes if signed_mode, raw values otherwise), latch neg = signed_mode & (a[MSB]^b[MSB]), clear the accumulator, clear the iteration counter, and go to CALC.
REQ-013 In IDLE with start=0, the block SHALL hold all registers.
REQ-014 In CALC, each cycle the block SHALL add the shifted multiplicand to the accumulator if the current multiplier LSB is 1, then shift the multiplier right and the multiplicand left by one (shift-add).
REQ-015 The block SHALL stay in CALC for exactly WIDTH cycles, counted by a ceil(log2(WIDTH+1))-bit counter, then go to SIGN.
REQ-016 In SIGN, the block SHALL register product = neg ? -acc : acc (2*WIDTH-bit two's complement), register done=1, and go to IDLE.
REQ-017 done SHALL be high for exactly the one cycle following the SIGN edge, which is WIDTH+1 clock edges after the edge that accepted start, and low otherwise.
REQ-018 A start asserted while busy=1 SHALL be ignored, with no effect on the operation in progress or on the result.
REQ-019 A start asserted in the cycle where done=1 (the FSM is in IDLE) SHALL be accepted, giving back-to-back operation with a throughput of one result per WIDTH+2 cycles.
REQ-020 Input changes on a, b or signed_mode after start is accepted SHALL NOT affect the result.
REQ-021 The magnitude of -2^(WIDTH-1) SHALL be represented as the unsigned value 2^(WIDTH-1) in WIDTH bits, with no overflow.
REQ-022 All 2*WIDTH-bit products SHALL be exact (unsigned max (2^W-1)^2; signed max 2^(2W-2)).
REQ-023 A zero operand SHALL still take the full latency and return product=0, with no early exit.

Reset
REQ-024 While rst_n=0, regardless of clk, the block SHALL force state=IDLE, busy=0, done=0, product=0, and clear the accumulator, operand registers, neg and counter.
REQ-025 Reset asserted mid-operation SHALL abort the operation, with no done pulse and product=0.
REQ-026 After reset deasserts, the first start SHALL be accepted normally.

Structure
REQ-027 The state encodings (IDLE=2'd0, CALC=2'd1, SIGN=2'd2) SHALL be defined in the shared package/header of multiplier constants.
REQ-028 The width-derived counter size SHALL be defined in that same shared package/header.
REQ-029 The block SHALL be a single module; the magnitude/negate logic SHALL be inline, with no sub-module.

Verification
REQ-030 WIDTH=4, unsigned, a=5, b=3, start for one cycle -> done 5 edges later, product=8'd15, busy high for 5 cycles.
REQ-031 WIDTH=4, unsigned, a=15, b=15 -> product=8'd225.
REQ-032 WIDTH=4, signed, a=-3 (4'hD), b=5 -> product=8'hF1 (-15).
REQ-033 WIDTH=4, signed, a=-8, b=-8 -> product=8'd64.
REQ-034 Start a=5, b=3, then re-pulse start with a=7, b=7 mid-CALC -> product=15, exactly one done; a start in the done cycle with a=2, b=6 -> second done after WIDTH+2 cycles, product=12.
REQ-035 Drop rst_n at CALC cycle 2 -> busy, done and product go to 0 immediately, no done afterwards; a new start after release multiplies correctly.
